// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the miniRV data-memory arbiter.
package mem_arbiter_pkg;

    // Width of the wait-state down-counter (WAIT_CYCLES is 0..15).
    localparam int WAIT_CNT_W = 4;

    // Width of the store byte-lane mask.
    localparam int MASK_W = 4;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Requester identity; the value doubles as the grant-vector bit index.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the arbiter.
// slave  = arbiter side, master = requesters and memory block side.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // Instruction-fetch requester
    logic                             i_req_valid;
    logic                             i_req_ready;
    logic [XLEN-1:0]                  i_req_addr;
    logic                             i_resp_valid;
    logic [XLEN-1:0]                  i_resp_data;
    // Load/store requester
    logic                             d_req_valid;
    logic                             d_req_ready;
    logic [XLEN-1:0]                  d_req_addr;
    logic                             d_req_wen;
    logic [XLEN-1:0]                  d_req_wdata;
    logic [mem_arbiter_pkg::MASK_W-1:0] d_req_wbmask;
    logic                             d_resp_valid;
    logic [XLEN-1:0]                  d_resp_data;
    // Memory block (combinational read, clocked write)
    logic                             mem_wen;
    logic [XLEN-1:0]                  mem_addr;
    logic [XLEN-1:0]                  mem_wdata;
    logic [mem_arbiter_pkg::MASK_W-1:0] mem_wbmask;
    logic [XLEN-1:0]                  mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wbmask,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_wen, mem_addr, mem_wdata, mem_wbmask,
        input  mem_rdata
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wbmask,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_wen, mem_addr, mem_wdata, mem_wbmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant. Bit 0 = fetch (I), bit 1 = load/store (D).
// The last grant starts at D so the first contention goes to I.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    req_e r_last_grant;

    // One-hot grant: a lone requester wins, on contention the one not granted last wins.
    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = (r_last_grant == REQ_D) ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only when the handshake actually takes place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= REQ_D;
        end else if (i_accept && (|o_grant)) begin
            r_last_grant <= o_grant[1] ? REQ_D : REQ_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port miniRV data memory between fetch (I) and
// load/store (D). One access in flight; optional wait states before the access.
// Optional statistics counters are built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    mem_arbiter_if.slave      bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                r_state;
    req_e                  r_owner;
    logic [XLEN-1:0]       r_addr;
    logic                  r_wen;
    logic [XLEN-1:0]       r_wdata;
    logic [MASK_W-1:0]     r_wbmask;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]       r_rdata;

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_pick_d;

    assign w_valid  = {bus.d_req_valid, bus.i_req_valid};
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & (|w_valid);
    assign w_pick_d = w_grant[REQ_D];

    rr_arbiter2 u_rr (
        .clock    (clock),
        .reset    (reset),
        .i_valid  (w_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Ready only in IDLE and only for the winner; responses only in RESP for the owner.
    assign bus.i_req_ready  = w_idle & w_grant[REQ_I];
    assign bus.d_req_ready  = w_idle & w_grant[REQ_D];
    assign bus.i_resp_valid = (r_state == RESP) && (r_owner == REQ_I);
    assign bus.d_resp_valid = (r_state == RESP) && (r_owner == REQ_D);
    assign bus.i_resp_data  = r_rdata;
    assign bus.d_resp_data  = r_rdata;

    // Memory buses come straight from the latched request; write strobe only in ACCESS.
    assign bus.mem_wen    = (r_state == ACCESS) && r_wen;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_wbmask = r_wbmask;

    // Access sequencer: latch on handshake, optional wait, single access cycle, response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= REQ_I;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wbmask <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner  <= w_pick_d ? REQ_D : REQ_I;
                        r_addr   <= w_pick_d ? bus.d_req_addr : bus.i_req_addr;
                        r_wen    <= w_pick_d & bus.d_req_wen;
                        r_wdata  <= w_pick_d ? bus.d_req_wdata : '0;
                        r_wbmask <= w_pick_d ? bus.d_req_wbmask : '0;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    r_rdata <= r_wen ? '0 : bus.mem_rdata;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    // Grant and contention counters, free-running with wrap-around.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (bus.i_req_ready) begin
                stat_i_grants <= stat_i_grants + 32'd1;
            end
            if (bus.d_req_ready) begin
                stat_d_grants <= stat_d_grants + 32'd1;
            end
            if (w_idle && (&w_valid)) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with WAIT_CYCLES=0 (dut0) and
// WAIT_CYCLES=3 (dut3), each with its own small memory model.
// Statistics checks are included when MEM_ARBITER_STATS_EN is defined.
module tb_mem_arbiter;

    logic clock;
    logic rst0;
    logic rst3;

    int n_vec = 0;
    int n_bad = 0;

    // Response / write-strobe tallies taken on the falling edge.
    int w0 = 0, ir0 = 0, dr0 = 0;
    int w3 = 0, ir3 = 0, dr3 = 0;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem3 [0:255];

    mem_arbiter_if #(.XLEN(32)) b0 ();
    mem_arbiter_if #(.XLEN(32)) b3 ();

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] s0_i, s0_d, s0_c;
    logic [31:0] s3_i, s3_d, s3_c;
`endif

    mem_arbiter #(.XLEN(32), .WAIT_CYCLES(0)) dut0 (
        .clock          (clock),
        .reset          (rst0),
        .bus            (b0)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_i_grants  (s0_i),
        .stat_d_grants  (s0_d),
        .stat_conflicts (s0_c)
`endif
    );

    mem_arbiter #(.XLEN(32), .WAIT_CYCLES(3)) dut3 (
        .clock          (clock),
        .reset          (rst3),
        .bus            (b3)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_i_grants  (s3_i),
        .stat_d_grants  (s3_d),
        .stat_conflicts (s3_c)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory models: combinational read, byte-masked write on the rising edge.
    assign b0.mem_rdata = mem0[b0.mem_addr[9:2]];
    assign b3.mem_rdata = mem3[b3.mem_addr[9:2]];

    always @(posedge clock) begin
        if (b0.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (b0.mem_wbmask[b]) mem0[b0.mem_addr[9:2]][8*b +: 8] <= b0.mem_wdata[8*b +: 8];
            end
        end
        if (b3.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (b3.mem_wbmask[b]) mem3[b3.mem_addr[9:2]][8*b +: 8] <= b3.mem_wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clock) begin
        if (b0.mem_wen)      w0++;
        if (b0.i_resp_valid) ir0++;
        if (b0.d_resp_valid) dr0++;
        if (b3.mem_wen)      w3++;
        if (b3.i_resp_valid) ir3++;
        if (b3.d_resp_valid) dr3++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete access on dut0: returns handshake wait, latency from handshake edge, data.
    task automatic acc0(input bit is_d, input logic [31:0] addr, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] data, output int lat, output int hsw);
        bit got;
        bit done;
        got  = 1'b0;
        done = 1'b0;
        data = '0;
        lat  = 0;
        hsw  = 0;
        @(posedge clock); #1;
        if (is_d) begin
            b0.d_req_valid  = 1'b1;
            b0.d_req_addr   = addr;
            b0.d_req_wen    = wen;
            b0.d_req_wdata  = wdata;
            b0.d_req_wbmask = mask;
        end else begin
            b0.i_req_valid  = 1'b1;
            b0.i_req_addr   = addr;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            got = is_d ? b0.d_req_ready : b0.i_req_ready;
            @(posedge clock); #1;
            if (got) break;
            hsw++;
        end
        check("acc0_handshake", {31'd0, got}, 32'd1);
        b0.i_req_valid = 1'b0;
        b0.d_req_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (is_d ? b0.d_resp_valid : b0.i_resp_valid) begin
                done = 1'b1;
                data = is_d ? b0.d_resp_data : b0.i_resp_data;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
        check("acc0_response", {31'd0, done}, 32'd1);
    endtask

    // Follows a dut3 fetch from its handshake edge to the response; valid is held until then.
    task automatic wait_i3(output logic [31:0] data, output int lat, output int rdy);
        bit got;
        got  = 1'b0;
        data = '0;
        lat  = 0;
        rdy  = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            lat++;
            @(negedge clock);
            if (b3.i_req_ready) rdy++;
            if (b3.i_resp_valid) begin
                got  = 1'b1;
                data = b3.i_resp_data;
                b3.i_req_valid = 1'b0;
                break;
            end
        end
        check("i3_response", {31'd0, got}, 32'd1);
    endtask

    initial begin
        logic [31:0] data;
        logic [3:0]  order;
        int lat, hsw, rdy, ng, both;

        for (int a = 0; a < 256; a++) begin
            mem0[a] = '0;
            mem3[a] = '0;
        end
        mem0[0] = 32'h0000_0013;
        mem3[0] = 32'h0000_0013;

        b0.i_req_valid = 0; b0.i_req_addr = '0;
        b0.d_req_valid = 0; b0.d_req_addr = '0; b0.d_req_wen = 0; b0.d_req_wdata = '0; b0.d_req_wbmask = '0;
        b3.i_req_valid = 0; b3.i_req_addr = '0;
        b3.d_req_valid = 0; b3.d_req_addr = '0; b3.d_req_wen = 0; b3.d_req_wdata = '0; b3.d_req_wbmask = '0;
        rst0 = 1'b1;
        rst3 = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_wen",    {31'd0, b0.mem_wen},      32'd0);
        check("rst_mem_addr",   b0.mem_addr,              32'd0);
        check("rst_mem_wdata",  b0.mem_wdata,             32'd0);
        check("rst_mem_wbmask", {28'd0, b0.mem_wbmask},   32'd0);
        check("rst_i_resp",     {31'd0, b0.i_resp_valid}, 32'd0);
        check("rst_d_resp",     {31'd0, b0.d_resp_valid}, 32'd0);
        check("rst_d_data",     b0.d_resp_data,           32'd0);
        check("rst3_mem_addr",  b3.mem_addr,              32'd0);
`ifdef MEM_ARBITER_STATS_EN
        check("rst_stat_i",     s0_i, 32'd0);
        check("rst_stat_c",     s0_c, 32'd0);
`endif
        rst0 = 1'b0;
        rst3 = 1'b0;

        // I-only fetch, no wait states
        acc0(1'b0, 32'h8000_0000, 1'b0, '0, '0, data, lat, hsw);
        #1;
        check("fetch_ready_delay", hsw,  32'd0);
        check("fetch_latency",     lat,  32'd2);
        check("fetch_data",        data, 32'h0000_0013);
        check("fetch_no_dresp",    dr0,  32'd0);
        check("fetch_iresp_count", ir0,  32'd1);

        // Masked store, then load back
        acc0(1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, data, lat, hsw);
        #1;
        check("store_wen_pulses", w0,   32'd1);
        check("store_resp_data",  data, 32'd0);
        check("store_latency",    lat,  32'd2);
        acc0(1'b1, 32'h8000_0100, 1'b0, '0, '0, data, lat, hsw);
        #1;
        check("load_data",        data, 32'h0000_BEEF);
        check("load_no_wen",      w0,   32'd1);

        // Continuous contention: I, D, I, D
        @(posedge clock); #1;
        b0.i_req_valid = 1'b1; b0.i_req_addr = 32'h8000_0000;
        b0.d_req_valid = 1'b1; b0.d_req_addr = 32'h8000_0100; b0.d_req_wen = 1'b0;
        order = '0; ng = 0; both = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clock);
            if (b0.i_req_ready && b0.d_req_ready) both++;
            if (b0.i_req_ready) begin
                order[ng] = 1'b0; ng++;
            end else if (b0.d_req_ready) begin
                order[ng] = 1'b1; ng++;
            end
            if (ng == 4) begin
                @(posedge clock); #1;
                b0.i_req_valid = 1'b0;
                b0.d_req_valid = 1'b0;
            end
        end
        check("rr_grants",     ng,              32'd4);
        check("rr_order",      {28'd0, order},  32'h0000_000A);
        check("rr_never_both", both,            32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rr_iresp_count", ir0, 32'd3);
        check("rr_dresp_count", dr0, 32'd4);
`ifdef MEM_ARBITER_STATS_EN
        check("stat_conflicts", s0_c, 32'd4);
`endif

        // D raises valid during the fetch's RESP cycle
        @(posedge clock); #1;
        b0.i_req_valid = 1'b1; b0.i_req_addr = 32'h8000_0000;
        @(negedge clock);
        check("resp_hs_ready", {31'd0, b0.i_req_ready}, 32'd1);
        @(posedge clock); #1;
        b0.i_req_valid = 1'b0;
        @(posedge clock); #1;
        b0.d_req_valid = 1'b1; b0.d_req_addr = 32'h8000_0100; b0.d_req_wen = 1'b0;
        @(negedge clock);
        check("resp_i_valid",     {31'd0, b0.i_resp_valid}, 32'd1);
        check("resp_d_blocked",   {31'd0, b0.d_req_ready},  32'd0);
        @(negedge clock);
        check("resp_d_ready_idle", {31'd0, b0.d_req_ready}, 32'd1);
        @(posedge clock); #1;
        b0.d_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("resp_dresp_count", dr0, 32'd5);
`ifdef MEM_ARBITER_STATS_EN
        check("stat_i_grants", s0_i, 32'd4);
        check("stat_d_grants", s0_d, 32'd5);
        check("stat_conflicts_final", s0_c, 32'd4);
`endif

        // WAIT_CYCLES=3 fetch, valid held until the response
        @(posedge clock); #1;
        b3.i_req_valid = 1'b1; b3.i_req_addr = 32'h8000_0000;
        @(negedge clock);
        check("w3_hs_ready", {31'd0, b3.i_req_ready}, 32'd1);
        wait_i3(data, lat, rdy);
        check("w3_latency",   lat,  32'd5);
        check("w3_ready_low", rdy,  32'd0);
        check("w3_data",      data, 32'h0000_0013);

        // Reset while a D store sits in WAIT
        @(posedge clock); #1;
        b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h8000_0100; b3.d_req_wen = 1'b1;
        b3.d_req_wdata = 32'hCAFE_F00D; b3.d_req_wbmask = 4'hF;
        @(negedge clock);
        check("rstw_d_ready", {31'd0, b3.d_req_ready}, 32'd1);
        @(posedge clock); #1;
        b3.d_req_valid = 1'b0;
        @(negedge clock);
        rst3 = 1'b1;
        #1;
        check("rstw_mem_addr",   b3.mem_addr,            32'd0);
        check("rstw_mem_wbmask", {28'd0, b3.mem_wbmask}, 32'd0);
        b3.i_req_valid = 1'b1; b3.i_req_addr = 32'h8000_0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst3 = 1'b0;
        #1;
        check("rstw_i_ready_first", {31'd0, b3.i_req_ready}, 32'd1);
        wait_i3(data, lat, rdy);
        #1;
        check("rstw_fetch_latency", lat,       32'd5);
        check("rstw_fetch_data",    data,      32'h0000_0013);
        check("rstw_no_wen",        w3,        32'd0);
        check("rstw_no_dresp",      dr3,       32'd0);
        check("rstw_mem_untouched", mem3[64],  32'd0);
        check("rstw_iresp_count",   ir3,       32'd2);
`ifdef MEM_ARBITER_STATS_EN
        check("rstw_stat_i", s3_i, 32'd1);
        check("rstw_stat_d", s3_d, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port miniRV data memory between the instruction-fetch requester (I) and the load/store requester (D).
- Round-robin arbitration; one access in flight at a time; optional wait states model slower memory.
- Sits between the core's fetch/LSU stages and the memory block (combinational read, write on clock edge).

Parameters:
- XLEN, 32, address/data width in bits.
- WAIT_CYCLES, 0, extra stall cycles inserted between grant and memory access (0..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req_valid  in  1  fetch request pending.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  XLEN  fetch byte address.
- i_resp_valid  out  1  fetch data valid (one-cycle pulse).
- i_resp_data  out  XLEN  fetched word.
- d_req_valid  in  1  load/store request pending.
- d_req_ready  out  1  load/store request accepted this cycle.
- d_req_addr  in  XLEN  load/store byte address.
- d_req_wen  in  1  1 = store, 0 = load.
- d_req_wdata  in  XLEN  store data.
- d_req_wbmask  in  4  store byte-lane mask.
- d_resp_valid  out  1  load data valid / store complete (one-cycle pulse).
- d_resp_data  out  XLEN  loaded word (0 for stores).
- mem_wen  out  1  memory write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_wbmask  out  4  memory byte mask.
- mem_rdata  in  XLEN  memory read data (combinational from mem_addr).

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP. Reset state IDLE.
- IDLE: handshake on the winner only. Ready is combinational: asserted for the winner when its valid is high, never for both.
- Arbitration: if only one valid, it wins. If both valid, the requester not granted last wins. last_grant resets to D, so the first contention goes to I. last_grant updates only on a handshake.
- On handshake, latch owner, addr, wen (forced 0 for I), wdata, wbmask. Next state is WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else ACCESS.
- WAIT: counter decrements each cycle; go to ACCESS when the counter is 0.
- ACCESS: lasts exactly 1 cycle. mem_wen = latched wen, asserted only in this cycle, so exactly one write per store. Capture mem_rdata into the response register (capture 0 if store). Next state RESP.
- RESP: the owner's resp_valid = 1 for exactly 1 cycle with data; no backpressure. Next state IDLE; no request is accepted in RESP.
- Latency: handshake at cycle t, ACCESS at t+1+WAIT_CYCLES, resp_valid at t+2+WAIT_CYCLES. Minimum 3 cycles per access.
- mem_addr/mem_wdata/mem_wbmask are always driven from the latched registers; mem_wen = 0 outside ACCESS.
- Reset values: all ready/resp_valid 0, resp data 0, mem_wen 0, mem_* buses 0, latched registers 0, counter 0.
- Reset asserted mid-operation: immediate return to IDLE. An in-flight access is dropped: no write if not yet in ACCESS, no response issued.
- Address alignment and wbmask are passed through unchecked.
- A requester dropping valid before its handshake is legal; no state change.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: adds outputs stat_i_grants, stat_d_grants and stat_conflicts, each 32-bit, reset to 0, wrapping on overflow.
  - stat_i_grants / stat_d_grants increment on each I / D handshake.
  - stat_conflicts increments each IDLE cycle in which both valids are high.
- Not defined: the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package mem_arbiter_pkg: state enum (IDLE, WAIT, ACCESS, RESP); requester enum (REQ_I, REQ_D); WAIT counter width constant (4).
- Sub-module rr_arbiter2: 2-input round-robin grant with last_grant register, inputs valid[1:0] and accept, output one-hot grant[1:0].

Test Plan:
- I-only fetch, WAIT_CYCLES=0, mem preloaded 0x00000013 @0x80000000 -> i_req_ready same cycle, i_resp_valid 2 cycles later with data 0x00000013, d_resp_valid never set.
- D store addr 0x80000100, wdata 0xDEADBEEF, wbmask 4'b0011 -> mem_wen high exactly 1 cycle; a subsequent D load of the same address returns 0x0000BEEF (prior contents 0); d_resp_data 0 on the store response.
- Both valid continuously for 4 accesses -> grant order I, D, I, D; stat_conflicts = 4 with MEM_ARBITER_STATS_EN.
- WAIT_CYCLES=3, I fetch -> resp_valid exactly 5 cycles after handshake; i_req_ready low throughout.
- Reset asserted in WAIT during a D store -> no mem_wen pulse, no d_resp_valid, FSM in IDLE; a new I request is accepted in the first cycle after reset deasserts.
- Valid raised during RESP -> ready stays low until IDLE, then asserted the following cycle.
